// File: rtl/gpu_raster_if.sv
// Command/status and framebuffer RAM signals of the 1-bpp raster engine.
//   slave  : the raster engine (consumes commands and RAM read data; drives
//            status and RAM address/enables/write data)
//   master : the command decoder / RAM side that drives the engine
interface gpu_raster_if #(
   parameter int XW        = 9,
   parameter int YW        = 8,
   parameter int WORD_BITS = 8
);
   logic                 cmd_valid;
   logic [1:0]           cmd_op;
   logic [1:0]           cmd_rop;
   logic [XW-1:0]        src_x;
   logic [YW-1:0]        src_y;
   logic [XW-1:0]        dst_x;
   logic [YW-1:0]        dst_y;
   logic [XW-1:0]        op_w;
   logic [YW-1:0]        op_h;
   logic                 fill_value;
   logic [WORD_BITS-1:0] wr_word;
   logic                 mem_rd_data;

   logic [XW-1:0]        mem_x;
   logic [YW-1:0]        mem_y;
   logic                 mem_rd_en;
   logic                 mem_wr_en;
   logic                 mem_wr_data;
   logic                 busy;
   logic                 done;
   logic                 error;
   logic [WORD_BITS-1:0] rd_word;
   logic                 rd_word_valid;

   modport slave (
      input  cmd_valid, cmd_op, cmd_rop, src_x, src_y, dst_x, dst_y,
             op_w, op_h, fill_value, wr_word, mem_rd_data,
      output mem_x, mem_y, mem_rd_en, mem_wr_en, mem_wr_data,
             busy, done, error, rd_word, rd_word_valid
   );

   modport master (
      output cmd_valid, cmd_op, cmd_rop, src_x, src_y, dst_x, dst_y,
             op_w, op_h, fill_value, wr_word, mem_rd_data,
      input  mem_x, mem_y, mem_rd_en, mem_wr_en, mem_wr_data,
             busy, done, error, rd_word, rd_word_valid
   );
endinterface

// File: rtl/gpu_raster_engine.sv
// 1-bit-per-pixel raster engine: rectangle FILL, overlap-safe BLIT with
// raster ops, and packed WORD_BITS-wide read/write. At most one RAM access
// per cycle; the engine owns the RAM address/enable lines while busy.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - gpu_raster_if.slave: command inputs, status outputs, RAM port
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a command
// FILL   | one pixel write per cycle, row-major
// B_RDS  | BLIT: read source pixel
// B_RDD  | BLIT: capture source bit, read destination (XOR/OR only)
// B_CAP  | BLIT: capture destination bit, register raster-op result
// B_WR   | BLIT: write result, step offsets
// W_RD   | READ_WORD: WORD_BITS reads plus one trailing capture cycle
// W_WR   | WRITE_WORD: WORD_BITS writes
// DONE   | one-cycle done pulse (also after a rejected command)
module gpu_raster_engine #(
   parameter int WIDTH     = 320,
   parameter int HEIGHT    = 200,
   parameter int XW        = 9,
   parameter int YW        = 8,
   parameter int WORD_BITS = 8
) (
   input logic         clk,
   input logic         rst_n,
   gpu_raster_if.slave bus
);
   localparam int IW = $clog2(WORD_BITS + 1);
   localparam logic [IW-1:0] WB_I  = IW'(WORD_BITS);
   localparam logic [XW:0]   LIM_X = (XW+1)'(WIDTH);
   localparam logic [YW:0]   LIM_Y = (YW+1)'(HEIGHT);
   localparam logic [XW:0]   WB_X  = (XW+1)'(WORD_BITS);

   localparam logic [1:0] OP_FILL = 2'd0;
   localparam logic [1:0] OP_BLIT = 2'd1;
   localparam logic [1:0] OP_RDW  = 2'd2;

   typedef enum logic [3:0] {
      S_IDLE, S_FILL, S_BRDS, S_BRDD, S_BCAP, S_BWR, S_WRD, S_WWR, S_DONE
   } state_t;

   state_t r_state, w_state_nx;

   logic [1:0]           r_op, r_rop;
   logic [XW-1:0]        r_sx, r_dx, r_w, r_ox;
   logic [YW-1:0]        r_sy, r_dy, r_h, r_oy;
   logic                 r_fill, r_rev, r_src_bit, r_res, r_error;
   logic [WORD_BITS-1:0] r_wr_sh, r_acc, r_rd_word;
   logic [IW-1:0]        r_i;

   logic                 w_busy, w_accept, w_reject, w_rev_in, w_last, w_rop_res;
   logic [XW:0]          w_dx_end, w_sx_end, w_dwx_end, w_swx_end;
   logic [YW:0]          w_dy_end, w_sy_end;
   logic [WORD_BITS-1:0] w_acc_next;

   // A rejected command parks in DONE with error set; busy stays low there.
   assign w_busy   = (r_state != S_IDLE) && !((r_state == S_DONE) && r_error);
   assign w_accept = bus.cmd_valid && !w_busy;

   // Bounds are checked one bit wider so that x+w cannot wrap.
   assign w_dx_end  = {1'b0, bus.dst_x} + {1'b0, bus.op_w};
   assign w_sx_end  = {1'b0, bus.src_x} + {1'b0, bus.op_w};
   assign w_dy_end  = {1'b0, bus.dst_y} + {1'b0, bus.op_h};
   assign w_sy_end  = {1'b0, bus.src_y} + {1'b0, bus.op_h};
   assign w_dwx_end = {1'b0, bus.dst_x} + WB_X;
   assign w_swx_end = {1'b0, bus.src_x} + WB_X;

   always_comb begin
      w_reject = 1'b0;
      case (bus.cmd_op)
         OP_FILL: w_reject = (bus.op_w == '0) || (bus.op_h == '0) ||
                             (w_dx_end > LIM_X) || (w_dy_end > LIM_Y);
         OP_BLIT: w_reject = (bus.op_w == '0) || (bus.op_h == '0) ||
                             (w_dx_end > LIM_X) || (w_dy_end > LIM_Y) ||
                             (w_sx_end > LIM_X) || (w_sy_end > LIM_Y);
         OP_RDW:  w_reject = (w_swx_end > LIM_X) || ({1'b0, bus.src_y} >= LIM_Y);
         default: w_reject = (w_dwx_end > LIM_X) || ({1'b0, bus.dst_y} >= LIM_Y);
      endcase
   end

   // Walking backwards when the destination lies after the source keeps
   // overlapping copies from reading already-overwritten pixels.
   assign w_rev_in = (bus.dst_y > bus.src_y) ||
                     ((bus.dst_y == bus.src_y) && (bus.dst_x > bus.src_x));

   assign w_last = r_rev ? ((r_ox == '0) && (r_oy == '0))
                         : ((r_ox == r_w - 1'b1) && (r_oy == r_h - 1'b1));

   assign w_acc_next = {bus.mem_rd_data, r_acc[WORD_BITS-1:1]};

   always_comb begin
      case (r_rop)
         2'd0:    w_rop_res = r_src_bit;
         2'd1:    w_rop_res = ~r_src_bit;
         2'd2:    w_rop_res = r_src_bit ^ bus.mem_rd_data;
         default: w_rop_res = r_src_bit | bus.mem_rd_data;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            w_state_nx = S_IDLE;
            if (w_accept) begin
               if (w_reject) w_state_nx = S_DONE;
               else begin
                  case (bus.cmd_op)
                     OP_FILL: w_state_nx = S_FILL;
                     OP_BLIT: w_state_nx = S_BRDS;
                     OP_RDW:  w_state_nx = S_WRD;
                     default: w_state_nx = S_WWR;
                  endcase
               end
            end
         end
         S_FILL:  if (w_last) w_state_nx = S_DONE;
         S_BRDS:  w_state_nx = S_BRDD;
         S_BRDD:  w_state_nx = S_BCAP;
         S_BCAP:  w_state_nx = S_BWR;
         S_BWR:   w_state_nx = w_last ? S_DONE : S_BRDS;
         S_WRD:   if (r_i == WB_I) w_state_nx = S_DONE;
         S_WWR:   if (r_i == WB_I - 1'b1) w_state_nx = S_DONE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op      <= '0;
         r_rop     <= '0;
         r_sx      <= '0;
         r_sy      <= '0;
         r_dx      <= '0;
         r_dy      <= '0;
         r_w       <= '0;
         r_h       <= '0;
         r_ox      <= '0;
         r_oy      <= '0;
         r_fill    <= 1'b0;
         r_rev     <= 1'b0;
         r_src_bit <= 1'b0;
         r_res     <= 1'b0;
         r_error   <= 1'b0;
         r_wr_sh   <= '0;
         r_acc     <= '0;
         r_rd_word <= '0;
         r_i       <= '0;
      end else if (w_accept) begin
         r_error <= w_reject;
         r_op    <= bus.cmd_op;
         r_rop   <= bus.cmd_rop;
         r_sx    <= bus.src_x;
         r_sy    <= bus.src_y;
         r_dx    <= bus.dst_x;
         r_dy    <= bus.dst_y;
         r_w     <= bus.op_w;
         r_h     <= bus.op_h;
         r_fill  <= bus.fill_value;
         r_wr_sh <= bus.wr_word;
         r_i     <= '0;
         r_rev   <= (bus.cmd_op == OP_BLIT) && w_rev_in;
         if ((bus.cmd_op == OP_BLIT) && w_rev_in) begin
            r_ox <= bus.op_w - 1'b1;
            r_oy <= bus.op_h - 1'b1;
         end else begin
            r_ox <= '0;
            r_oy <= '0;
         end
      end else begin
         case (r_state)
            S_FILL, S_BWR: begin
               if (!w_last) begin
                  if (r_rev) begin
                     if (r_ox == '0) begin
                        r_ox <= r_w - 1'b1;
                        r_oy <= r_oy - 1'b1;
                     end else r_ox <= r_ox - 1'b1;
                  end else begin
                     if (r_ox == r_w - 1'b1) begin
                        r_ox <= '0;
                        r_oy <= r_oy + 1'b1;
                     end else r_ox <= r_ox + 1'b1;
                  end
               end
            end
            S_BRDD: r_src_bit <= bus.mem_rd_data;
            S_BCAP: r_res     <= w_rop_res;
            S_WRD: begin
               r_i <= r_i + 1'b1;
               if (r_i != '0) r_acc <= w_acc_next;
               if (r_i == WB_I) r_rd_word <= w_acc_next;
            end
            S_WWR: begin
               r_i     <= r_i + 1'b1;
               r_wr_sh <= r_wr_sh >> 1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.mem_x         = '0;
      bus.mem_y         = '0;
      bus.mem_rd_en     = 1'b0;
      bus.mem_wr_en     = 1'b0;
      bus.mem_wr_data   = 1'b0;
      bus.busy          = w_busy;
      bus.done          = (r_state == S_DONE);
      bus.error         = r_error;
      bus.rd_word       = r_rd_word;
      bus.rd_word_valid = (r_state == S_DONE) && (r_op == OP_RDW) && !r_error;
      case (r_state)
         S_FILL: begin
            bus.mem_x       = r_dx + r_ox;
            bus.mem_y       = r_dy + r_oy;
            bus.mem_wr_en   = 1'b1;
            bus.mem_wr_data = r_fill;
         end
         S_BRDS: begin
            bus.mem_x     = r_sx + r_ox;
            bus.mem_y     = r_sy + r_oy;
            bus.mem_rd_en = 1'b1;
         end
         S_BRDD: begin
            bus.mem_x     = r_dx + r_ox;
            bus.mem_y     = r_dy + r_oy;
            bus.mem_rd_en = r_rop[1];
         end
         S_BCAP: begin
            bus.mem_x = r_dx + r_ox;
            bus.mem_y = r_dy + r_oy;
         end
         S_BWR: begin
            bus.mem_x       = r_dx + r_ox;
            bus.mem_y       = r_dy + r_oy;
            bus.mem_wr_en   = 1'b1;
            bus.mem_wr_data = r_res;
         end
         S_WRD: begin
            bus.mem_x     = r_sx + XW'(r_i);
            bus.mem_y     = r_sy;
            bus.mem_rd_en = (r_i != WB_I);
         end
         S_WWR: begin
            bus.mem_x       = r_dx + XW'(r_i);
            bus.mem_y       = r_dy;
            bus.mem_wr_en   = 1'b1;
            bus.mem_wr_data = r_wr_sh[0];
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_gpu_raster_engine.sv
module tb_gpu_raster_engine;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   gpu_raster_if #(.XW(9), .YW(8), .WORD_BITS(8)) bus ();

   gpu_raster_engine #(
      .WIDTH(320), .HEIGHT(200), .XW(9), .YW(8), .WORD_BITS(8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int t0       = 0;
   int n_both   = 0;

   logic [319:0] fb [0:199];
   logic         rd_pend = 1'b0;
   logic [31:0]  wlog [$];
   logic [31:0]  rlog [$];

   int   done_rel;
   logic busy1, busy_at, err_at, rwv_at, busy_after;

   function automatic logic [31:0] enc(input int x, input int y, input int d, input int c);
      return {8'(c), 6'd0, 1'(d), 8'(y), 9'(x)};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Framebuffer model: writes land mid-cycle, read data appears the next cycle.
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.mem_rd_en && bus.mem_wr_en) n_both++;
      if (bus.mem_wr_en) begin
         fb[int'(bus.mem_y)][int'(bus.mem_x)] = bus.mem_wr_data;
         wlog.push_back(enc(int'(bus.mem_x), int'(bus.mem_y), int'(bus.mem_wr_data), cyc - t0));
      end
      if (bus.mem_rd_en) begin
         rd_pend = fb[int'(bus.mem_y)][int'(bus.mem_x)];
         rlog.push_back(enc(int'(bus.mem_x), int'(bus.mem_y), int'(rd_pend), cyc - t0));
      end
   end

   always @(posedge clk) begin
      #1 bus.mem_rd_data = rd_pend;
   end

   task automatic set_cmd(input int op, input int rop, input int sx, input int sy,
                          input int dx, input int dy, input int w, input int h,
                          input int fv, input int ww);
      bus.cmd_op     = 2'(op);
      bus.cmd_rop    = 2'(rop);
      bus.src_x      = 9'(sx);
      bus.src_y      = 8'(sy);
      bus.dst_x      = 9'(dx);
      bus.dst_y      = 8'(dy);
      bus.op_w       = 9'(w);
      bus.op_h       = 8'(h);
      bus.fill_value = 1'(fv);
      bus.wr_word    = 8'(ww);
   endtask

   // Issue one command and wait (bounded) for done; cycle numbers are relative
   // to the accept cycle, so the first cycle after accept is 1.
   task automatic run(input string tag, input int op, input int rop, input int sx,
                      input int sy, input int dx, input int dy, input int w,
                      input int h, input int fv, input int ww);
      bit got_done = 0;
      set_cmd(op, rop, sx, sy, dx, dy, w, h, fv, ww);
      wlog.delete();
      rlog.delete();
      t0 = cyc;
      bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      busy1 = bus.busy;
      done_rel = -1;
      for (int k = 0; k < 200 && !got_done; k++) begin
         if (bus.done) begin
            got_done = 1;
            done_rel = cyc - t0;
            busy_at  = bus.busy;
            err_at   = bus.error;
            rwv_at   = bus.rd_word_valid;
         end else begin
            @(posedge clk); #1;
         end
      end
      if (!got_done) check({tag, "_timeout"}, 32'd0, 32'd1);
      @(posedge clk); #1;
      busy_after = bus.busy;
   endtask

   logic [7:0] pat;
   logic [7:0] ww;
   int nw;

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1);
   end

   initial begin
      for (int y = 0; y < 200; y++) fb[y] = '0;
      bus.cmd_valid = 1'b0;
      set_cmd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctl", {25'd0, bus.busy, bus.done, bus.error, bus.mem_rd_en,
                        bus.mem_wr_en, bus.mem_wr_data, bus.rd_word_valid}, 32'd0);
      check("rst_addr", {15'd0, bus.mem_x, bus.mem_y}, 32'd0);
      check("rst_rdword", 32'(bus.rd_word), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // FILL 3x2 at (10,5)
      run("fill", 0, 0, 0, 0, 10, 5, 3, 2, 1, 0);
      check("fill_busy1", 32'(busy1), 32'd1);
      check("fill_nwr", 32'(wlog.size()), 32'd6);
      for (int i = 0; i < 6; i++)
         check("fill_wr", (i < wlog.size()) ? wlog[i] : 32'hFFFF_FFFF,
               enc(10 + i % 3, 5 + i / 3, 1, i + 1));
      check("fill_nrd", 32'(rlog.size()), 32'd0);
      check("fill_done", 32'(done_rel), 32'd7);
      check("fill_busy_after", 32'(busy_after), 32'd0);

      // BLIT COPY overlapping, right shift by 2: must run in reverse
      fb[0][5:0] = 6'b001101;
      run("blit_copy", 1, 0, 0, 0, 2, 0, 4, 1, 0, 0);
      check("copy_nrd", 32'(rlog.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         check("copy_rd", (i < rlog.size()) ? rlog[i] : 32'hFFFF_FFFF,
               enc(3 - i, 0, (i == 2) ? 0 : 1, 1 + 4 * i));
      check("copy_nwr", 32'(wlog.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         check("copy_wr", (i < wlog.size()) ? wlog[i] : 32'hFFFF_FFFF,
               enc(5 - i, 0, (i == 2) ? 0 : 1, 4 + 4 * i));
      check("copy_result", 32'(fb[0][5:2]), 32'b1101);
      check("copy_done", 32'(done_rel), 32'd17);

      // 1x1 raster ops
      fb[20][50] = 1'b1; fb[20][60] = 1'b1;
      run("blit_xor", 1, 2, 50, 20, 60, 20, 1, 1, 0, 0);
      check("xor_nrd", 32'(rlog.size()), 32'd2);
      check("xor_dst_rd", (rlog.size() > 1) ? rlog[1] : 32'hFFFF_FFFF, enc(60, 20, 1, 2));
      check("xor_wr", (wlog.size() > 0) ? wlog[0] : 32'hFFFF_FFFF, enc(60, 20, 0, 4));
      check("xor_result", 32'(fb[20][60]), 32'd0);
      check("xor_done", 32'(done_rel), 32'd5);

      fb[21][50] = 1'b0; fb[21][60] = 1'b1;
      run("blit_or", 1, 3, 50, 21, 60, 21, 1, 1, 0, 0);
      check("or_nrd", 32'(rlog.size()), 32'd2);
      check("or_wr", (wlog.size() > 0) ? wlog[0] : 32'hFFFF_FFFF, enc(60, 21, 1, 4));

      fb[22][50] = 1'b1; fb[22][60] = 1'b1;
      run("blit_not", 1, 1, 50, 22, 60, 22, 1, 1, 0, 0);
      check("not_nrd", 32'(rlog.size()), 32'd1);
      check("not_result", 32'(fb[22][60]), 32'd0);

      // READ_WORD at (100,50)
      pat = 8'b10111001;
      for (int i = 0; i < 8; i++) fb[50][100 + i] = pat[i];
      run("rdw", 2, 0, 100, 50, 0, 0, 0, 0, 0, 0);
      check("rdw_nrd", 32'(rlog.size()), 32'd8);
      for (int i = 0; i < 8; i++)
         check("rdw_rd", (i < rlog.size()) ? rlog[i] : 32'hFFFF_FFFF,
               enc(100 + i, 50, int'(pat[i]), 1 + i));
      check("rdw_done", 32'(done_rel), 32'd10);
      check("rdw_valid", 32'(rwv_at), 32'd1);
      check("rdw_word", 32'(bus.rd_word), 32'hB9);
      check("rdw_valid_after", 32'(bus.rd_word_valid), 32'd0);

      // WRITE_WORD 0xA5 at (0,0)
      ww = 8'hA5;
      run("wrw", 3, 0, 0, 0, 0, 0, 0, 0, 0, 32'hA5);
      nw = wlog.size();
      check("wrw_nwr", 32'(nw), 32'd8);
      for (int i = 0; i < 8; i++)
         check("wrw_wr", (i < nw) ? wlog[i] : 32'hFFFF_FFFF, enc(i, 0, int'(ww[i]), 1 + i));
      check("wrw_pixels", 32'(fb[0][7:0]), 32'hA5);
      check("wrw_done", 32'(done_rel), 32'd9);
      check("wrw_rdword_held", 32'(bus.rd_word), 32'hB9);

      // Rejections and boundary
      run("rej_fill", 0, 0, 0, 0, 318, 0, 3, 1, 1, 0);
      check("rej_fill_err", 32'(err_at), 32'd1);
      check("rej_fill_done", 32'(done_rel), 32'd1);
      check("rej_fill_busy", 32'(busy_at), 32'd0);
      check("rej_fill_noacc", 32'(wlog.size() + rlog.size()), 32'd0);
      check("rej_fill_held", 32'(bus.error), 32'd1);

      run("edge_fill", 0, 0, 0, 0, 317, 10, 3, 1, 1, 0);
      check("edge_fill_err", 32'(err_at), 32'd0);
      check("edge_fill_done", 32'(done_rel), 32'd4);
      check("edge_fill_pix", 32'(fb[10][319:317]), 32'b111);

      run("rej_rdw", 2, 0, 313, 0, 0, 0, 0, 0, 0, 0);
      check("rej_rdw_err", 32'(err_at), 32'd1);
      check("rej_rdw_valid", 32'(rwv_at), 32'd0);
      check("rej_rdw_noacc", 32'(rlog.size()), 32'd0);

      run("rej_blit", 1, 0, 0, 198, 100, 0, 2, 3, 0, 0);
      check("rej_blit_err", 32'(err_at), 32'd1);
      check("rej_blit_noacc", 32'(wlog.size() + rlog.size()), 32'd0);

      run("rej_wrw", 3, 0, 0, 0, 0, 200, 0, 0, 0, 8'hFF);
      check("rej_wrw_err", 32'(err_at), 32'd1);

      // Reset in the middle of a BLIT
      set_cmd(1, 0, 0, 0, 1, 1, 4, 4, 0, 0);
      bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("midrst_busy_before", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_ctl", {25'd0, bus.busy, bus.done, bus.error, bus.mem_rd_en,
                           bus.mem_wr_en, bus.mem_wr_data, bus.rd_word_valid}, 32'd0);
      check("midrst_addr", {15'd0, bus.mem_x, bus.mem_y}, 32'd0);
      nw = wlog.size();
      repeat (3) @(posedge clk);
      #1;
      check("midrst_nowr", 32'(wlog.size()), 32'(nw));
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("postrst_busy", 32'(bus.busy), 32'd0);
      run("postrst_fill", 0, 0, 0, 0, 40, 40, 1, 1, 1, 0);
      check("postrst_done", 32'(done_rel), 32'd2);
      check("postrst_pix", 32'(fb[40][40]), 32'd1);

      check("rd_wr_exclusive", 32'(n_both), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/gpu_raster_engine.md
Name: gpu_raster_engine

Overview:
Parametrised successor to the current GPU operation block: a 1-bit-per-pixel raster engine between the command decoder and the framebuffer RAM port.
- Operations: rectangle FILL, overlap-safe BLIT with raster ops (COPY/NOT/XOR/OR), and WORD_BITS-wide packed read/write.
- One memory access per cycle max; the engine owns the RAM address/enable lines while busy.

Parameters:
WIDTH, 320, framebuffer width in pixels
HEIGHT, 200, framebuffer height in pixels
XW, 9, x coordinate/width bit count (2^XW > WIDTH)
YW, 8, y coordinate/height bit count (2^YW > HEIGHT)
WORD_BITS, 8, pixels per READ_WORD/WRITE_WORD

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command strobe, accepted when cmd_valid && !busy
cmd_op  in  2  0 FILL, 1 BLIT, 2 READ_WORD, 3 WRITE_WORD
cmd_rop  in  2  BLIT op: 0 COPY, 1 NOT src, 2 src XOR dst, 3 src OR dst
src_x / src_y  in  XW / YW  BLIT source, READ_WORD start
dst_x / dst_y  in  XW / YW  FILL/BLIT destination, WRITE_WORD start
op_w / op_h  in  XW / YW  rectangle size (FILL, BLIT)
fill_value  in  1  FILL pixel value
wr_word  in  WORD_BITS  WRITE_WORD data, bit i -> pixel x+i
mem_rd_data  in  1  RAM read data, valid the cycle after mem_rd_en
mem_x / mem_y  out  XW / YW  RAM pixel address
mem_rd_en / mem_wr_en  out  1  RAM read / write enable
mem_wr_data  out  1  RAM write data
busy  out  1  high from the cycle after accept until done
done  out  1  one-cycle pulse at op end (including error)
error  out  1  set on a rejected command, held until the next accept
rd_word  out  WORD_BITS  READ_WORD result, held until the next READ_WORD completes
rd_word_valid  out  1  one-cycle pulse together with done for READ_WORD

Behaviour:
- Reset: every output 0; state IDLE; internal counters 0. Reset mid-operation aborts immediately: enables drop asynchronously and no further writes occur.
- All command inputs are latched at accept; changes while busy are ignored. cmd_valid while busy is dropped, not queued.
- Rejection checks, computed at XW+1/YW+1 width with no wrap:
  - FILL/BLIT: op_w==0, op_h==0, x+op_w>WIDTH or y+op_h>HEIGHT for either rectangle used.
  - WORD ops: x+WORD_BITS>WIDTH, or y>=HEIGHT.
  - On rejection: error=1; the next cycle has done=1 and busy=0; no RAM access.
- States: IDLE, FILL, B_RDS, B_RDD, B_CAP, B_WR, W_RD, W_WR, DONE. DONE lasts one cycle (done=1) and then returns to IDLE.
- FILL: write cycles start the cycle after accept, with mem_wr_en=1 for exactly op_w*op_h consecutive cycles. Order is row-major: x increments, and at x==dst_x+op_w-1 it wraps to dst_x and y increments. Then DONE.
- BLIT, 4 cycles per pixel, total 4*op_w*op_h + 1 cycles to done:
  - B_RDS: mem_rd_en=1, address = src.
  - B_RDD: src bit captured. Address = dst; mem_rd_en=1 only for rop 2/3, else 0.
  - B_CAP: dst bit captured (when read). The result is registered.
  - B_WR: mem_wr_en=1, address = dst, mem_wr_data = result.
- BLIT direction:
  - reverse = (dst_y>src_y) || (dst_y==src_y && dst_x>src_x).
  - Forward: offsets start at (0,0), run row-major, and increment.
  - Reverse: offsets start at (op_w-1,op_h-1) and decrement x; at x==0 they wrap to op_w-1 and decrement y.
  - Result: overlapping copies match a non-overlapping copy.
- READ_WORD (W_RD):
  - mem_rd_en=1 for WORD_BITS cycles, addresses src_x+i, src_y.
  - Bit i is captured the cycle after its address.
  - rd_word updates and rd_word_valid/done pulse WORD_BITS+1 cycles after the first read cycle.
- WRITE_WORD (W_WR): mem_wr_en=1 for WORD_BITS cycles, writing dst_x+i with wr_word[i]. Then DONE.
- mem_rd_en and mem_wr_en are never high in the same cycle. Both are 0 in IDLE and DONE.
- error clears on the next accepted valid command.

Test Plan:
- FILL dst(10,5) op_w=3 op_h=2 value=1 -> 6 consecutive writes to (10,5),(11,5),(12,5),(10,6),(11,6),(12,6); done pulses the cycle after the last write; busy=0 the following cycle.
- BLIT COPY src(0,0) dst(2,0) 4x1, src pattern 1,0,1,1 -> reverse order; dst x=2..5 ends 1,0,1,1; source pixels 2,3 were read before being overwritten; done at cycle 17.
- BLIT XOR 1x1 with src=1, dst=1 -> dst becomes 0. OR with src=0, dst=1 -> 1. NOT with src=1 -> 0. Each shows a dst read in B_RDD only for XOR/OR.
- READ_WORD at (100,50) over pixels 1,0,0,1,1,1,0,1 (x+0..7) -> rd_word=8'b10111001 with rd_word_valid at cycle 9 after first read; then WRITE_WORD 8'hA5 at (0,0) -> pixels x0..7 = 1,0,1,0,0,1,0,1.
- FILL dst_x=318 op_w=3 (318+3>320) -> error=1, done next cycle, zero RAM enables. The next valid FILL clears error.
- rst_n asserted low mid-BLIT -> all outputs 0 immediately; after release, busy=0 and a new command is accepted.
